// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage for the single-cycle MIPS CPU.
// Holds the PC, fetches one word per instruction over a req/ready handshake,
// presents it to the decoder, and advances the PC when the datapath commits.
// Optional build macro: RETIRE_CNT_EN adds a 32-bit retired-instruction counter.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        branch,
    input  logic        jump,
    input  logic        alu_zero,
    input  logic        commit,
    input  logic        stall
`ifdef RETIRE_CNT_EN
    ,
    output logic [31:0] retire_cnt
`endif
);

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] next_pc;
    logic [31:0] branch_off;
    logic        commit_acc;

    assign pc_plus4   = pc_q + 32'd4;
    assign pc         = pc_q;
    assign imem_addr  = pc_q;
    assign instr      = instr_q;
    // Branch displacement: sign-extended word offset, already scaled to bytes.
    assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign commit_acc = (state_q == EXEC) && commit && !stall;

    // Next-PC selection: jump beats a taken branch, which beats fall-through.
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        end else if (branch && alu_zero) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

    // FSM next-state and outputs; stall freezes every transition.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            FETCH: begin
                // Request is suppressed while reset is held low.
                imem_req = rst_n;
                if (imem_ready && !stall) begin
                    instr_d = imem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                instr_valid = 1'b1;
                if (commit_acc) begin
                    pc_d    = next_pc;
                    state_d = FETCH;
                end
            end
        endcase
    end

    // State, PC and instruction registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

`ifdef RETIRE_CNT_EN
    logic [31:0] retire_cnt_q, retire_cnt_d;

    assign retire_cnt_d = commit_acc ? retire_cnt_q + 32'd1 : retire_cnt_q;
    assign retire_cnt   = retire_cnt_q;

    // Retired-instruction counter; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retire_cnt_q <= 32'd0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a behavioural model and literal checks.
module tb_fetch_unit;

    localparam logic [31:0] RST_A = 32'h0000_0000;
    localparam logic [31:0] RST_B = 32'h4000_0010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        branch, jump, alu_zero, commit, stall;

    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr, pc, pc_plus4;
    logic        b_req, b_valid;
    logic [31:0] b_addr, b_instr, b_pc, b_pc4;
`ifdef RETIRE_CNT_EN
    logic [31:0] retire_cnt, b_retire_cnt;
`endif

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_A)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .pc_plus4(pc_plus4),
        .branch(branch), .jump(jump), .alu_zero(alu_zero),
        .commit(commit), .stall(stall)
`ifdef RETIRE_CNT_EN
        , .retire_cnt(retire_cnt)
`endif
    );

    // Second instance with a high reset PC, used for the jump-region test.
    fetch_unit #(.RESET_PC(RST_B)) u_dut_hi (
        .clk(clk), .rst_n(rst_n),
        .imem_req(b_req), .imem_addr(b_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(b_instr), .instr_valid(b_valid),
        .pc(b_pc), .pc_plus4(b_pc4),
        .branch(branch), .jump(jump), .alu_zero(alu_zero),
        .commit(commit), .stall(stall)
`ifdef RETIRE_CNT_EN
        , .retire_cnt(b_retire_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic        m_init = 1'b0;
    logic        m_busy;
    logic [31:0] m_pc, m_instr, m_cnt;

    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                               input logic br, input logic jp, input logic z);
        logic [31:0] seq;
        int          off;
        seq = p + 32'd4;
        if (jp) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 32'd4);
        if (br && z) begin
            off = int'($signed(w[15:0])) * 4;
            return seq + 32'(off);
        end
        return seq;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_init  = 1'b1;
            m_busy  = 1'b0;
            m_pc    = RST_A;
            m_instr = 32'd0;
            m_cnt   = 32'd0;
        end else if (m_init && !stall) begin
            if (!m_busy && imem_ready) begin
                m_instr = imem_rdata;
                m_busy  = 1'b1;
            end else if (m_busy && commit) begin
                m_pc   = model_next(m_pc, m_instr, branch, jump, alu_zero);
                m_busy = 1'b0;
                m_cnt  = m_cnt + 32'd1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_init) begin
            chk("m_req",   {31'd0, imem_req},    {31'd0, rst_n && !m_busy});
            chk("m_addr",  imem_addr,            m_pc);
            chk("m_valid", {31'd0, instr_valid}, {31'd0, m_busy});
            chk("m_instr", instr,                m_instr);
            chk("m_pc",    pc,                   m_pc);
            chk("m_pc4",   pc_plus4,             m_pc + 32'd4);
`ifdef RETIRE_CNT_EN
            chk("m_retire", retire_cnt,          m_cnt);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full instruction: fetch accepted immediately, then committed.
    task automatic run_instr(input logic [31:0] w, input logic br, input logic jp, input logic z);
        imem_rdata = w;
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        branch = br; jump = jp; alu_zero = z; commit = 1'b1;
        tick();
        commit = 1'b0; branch = 1'b0; jump = 1'b0; alu_zero = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; imem_ready = 1'b1; imem_rdata = 32'd0;
        branch = 1'b0; jump = 1'b0; alu_zero = 1'b0; commit = 1'b0; stall = 1'b0;
        tick(); tick();
        chk("rst_pc",    pc, RST_A);
        chk("rst_instr", instr, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_req",   {31'd0, imem_req}, 32'd0);
        chk("rst_pc_hi", b_pc, RST_B);

        // Basic fetch / commit with memory ready immediately.
        rst_n = 1'b1;
        imem_rdata = 32'h2008_0005;
        #1;
        chk("first_req",  {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        tick();
        chk("first_valid", {31'd0, instr_valid}, 32'd1);
        chk("first_instr", instr, 32'h2008_0005);
        commit = 1'b1;                 // imem_ready still 1 in EXEC: ignored
        tick();
        commit = 1'b0; imem_ready = 1'b0;
        chk("commit_pc",  pc, 32'h4);
        chk("commit_req", {31'd0, imem_req}, 32'd1);

        // Walk to 0x10, then memory answers three cycles late.
        run_instr(32'h0000_0020, 1'b0, 1'b0, 1'b0);
        run_instr(32'h0000_0020, 1'b0, 1'b0, 1'b0);
        run_instr(32'h0000_0020, 1'b0, 1'b0, 1'b0);
        chk("walk_pc", pc, 32'h10);
        commit = 1'b1;                 // commit in FETCH: ignored
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_addr",  imem_addr, 32'h10);
            chk("wait_valid", {31'd0, instr_valid}, 32'd0);
        end
        commit = 1'b0;
        imem_rdata = 32'h8C01_0004;
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        chk("late_valid", {31'd0, instr_valid}, 32'd1);
        chk("late_instr", instr, 32'h8C01_0004);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("late_pc", pc, 32'h14);

        // Jump to 0x20, then taken / not-taken branch with imm = -2.
        run_instr(32'h0800_0008, 1'b0, 1'b1, 1'b0);
        chk("j_pc", pc, 32'h20);
        run_instr(32'h1000_FFFE, 1'b1, 1'b0, 1'b1);
        chk("beq_taken", pc, 32'h1C);
        run_instr(32'h0000_0020, 1'b0, 1'b0, 1'b0);
        chk("back_pc", pc, 32'h20);
        run_instr(32'h1000_FFFE, 1'b1, 1'b0, 1'b0);
        chk("beq_not_taken", pc, 32'h24);

        // Stall beats imem_ready in FETCH and commit in EXEC.
        stall = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h0000_0025;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall_f_valid", {31'd0, instr_valid}, 32'd0);
            chk("stall_f_addr",  imem_addr, 32'h24);
        end
        stall = 1'b0;
        tick();
        imem_ready = 1'b0;
        chk("unstall_valid", {31'd0, instr_valid}, 32'd1);
        stall = 1'b1; commit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_e_pc",    pc, 32'h24);
            chk("stall_e_valid", {31'd0, instr_valid}, 32'd1);
        end
        stall = 1'b0;
        tick();
        commit = 1'b0;
        chk("unstall_pc", pc, 32'h28);

        // Reset in the middle of a fetch; ready during reset is ignored.
        tick();
        rst_n = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("mid_rst_pc",    pc, RST_A);
        chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("mid_rst_req",   {31'd0, imem_req}, 32'd0);
        chk("mid_rst_pc_hi", b_pc, RST_B);
        rst_n = 1'b1; imem_ready = 1'b0;
        tick();
        chk("post_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("post_rst_req",   {31'd0, imem_req}, 32'd1);

        // Jump beats branch; high instance keeps the pc_plus4 top nibble.
        run_instr(32'h0800_0100, 1'b1, 1'b1, 1'b1);
        chk("jump_hi_pc", b_pc, 32'h4000_0400);
        chk("jump_lo_pc", pc, 32'h0000_0400);

        // Branch back to the top word, then wrap to zero.
        run_instr(32'h1000_FEFE, 1'b1, 1'b0, 1'b1);
        chk("top_pc",  pc, 32'hFFFF_FFFC);
        chk("top_pc4", pc_plus4, 32'h0);
        run_instr(32'h0000_0020, 1'b0, 1'b0, 1'b0);
        chk("wrap_pc", pc, 32'h0);

`ifdef RETIRE_CNT_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("retire_rst", retire_cnt, 32'd0);
        for (int i = 0; i < 4; i++) run_instr(32'h0000_0020, 1'b0, 1'b0, 1'b0);
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0; stall = 1'b1; commit = 1'b1;
        tick();
        stall = 1'b0; commit = 1'b0;
        tick();
        chk("retire_four", retire_cnt, 32'd4);
`endif

        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the single-cycle MIPS CPU. Sits directly upstream of the main control decoder.
- Holds the PC and fetches one instruction word per instruction over a req/ready memory handshake.
- Presents the held instruction to the decoder and datapath, then computes the next PC from the decoder's branch/jump outputs and the ALU zero flag when the datapath commits.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- clk, input, 1, single system clock; all state changes on rising edge.
- rst_n, input, 1, synchronous active-low reset.
- imem_req, output, 1, fetch request to instruction memory.
- imem_addr, output, 32, fetch address; equals pc.
- imem_ready, input, 1, memory has imem_rdata valid this cycle; only meaningful while imem_req=1.
- imem_rdata, input, 32, instruction word from memory.
- instr, output, 32, held instruction; bits 31:26 drive the decoder opcode.
- instr_valid, output, 1, instr is valid and executing.
- pc, output, 32, address of the current instruction.
- pc_plus4, output, 32, pc+4 (combinational, modulo 2^32).
- branch, input, 1, from decoder: beq.
- jump, input, 1, from decoder: j.
- alu_zero, input, 1, ALU zero flag.
- commit, input, 1, datapath finished the current instruction (register/memory write done this edge).
- stall, input, 1, freeze the PC and state machine.

Behaviour:
- Reset (rst_n=0 sampled at an edge):
  - pc=RESET_PC, instr=0, instr_valid=0, state=FETCH.
  - imem_req is forced to 0 while rst_n=0.
  - Reset aborts any outstanding fetch; a late imem_ready is ignored.
- States:
  - FETCH: imem_req=1, imem_addr=pc, instr_valid=0. At an edge with imem_ready=1 and stall=0: instr<=imem_rdata, instr_valid<=1, go to EXEC. Otherwise stay; pc and imem_addr stay stable.
  - EXEC: imem_req=0, instr_valid=1. At an edge with commit=1 and stall=0: pc<=next_pc, instr_valid<=0, go to FETCH. Otherwise hold everything.
- next_pc priority:
  1. jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}.
  2. else branch=1 and alu_zero=1: pc_plus4 + (sign-extend(instr[15:0]) << 2).
  3. else: pc_plus4.
- Arithmetic: all 32-bit, modulo 2^32; pc 32'hFFFF_FFFC + 4 wraps to 0. Target bits 1:0 are always 00.
- Boundary and simultaneous events:
  - commit while in FETCH: ignored.
  - imem_ready while in EXEC: ignored.
  - stall has priority over imem_ready and commit.
  - branch and jump both 1: jump wins.
- Latency: with imem_ready=1 in the first FETCH cycle, instr_valid rises 1 cycle later. Commit in that cycle starts the next fetch on the following cycle. Minimum 2 cycles per instruction.
- imem_addr changes only on the transition into FETCH.

Optional Feature:
- Macro: RETIRE_CNT_EN.
- Defined: adds output retire_cnt [31:0].
  - Reset to 0; increments by 1 on each accepted commit (EXEC, commit=1, stall=0).
  - Wraps from 32'hFFFF_FFFF to 0.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, RESET_PC=0, imem_ready held 1 -> cycle after release: imem_req=1, addr=0. Next cycle: instr_valid=1, instr=imem_rdata. After commit: pc=4, imem_req=1.
- Sequential fetch with memory delay: imem_ready asserted 3 cycles after req -> imem_addr stable at 0x10 for all 3 cycles. instr_valid rises only after ready.
- Branch taken:
  - pc=0x20, instr imm=16'hFFFE, branch=1, alu_zero=1, commit -> pc=0x1C.
  - Same with alu_zero=0 -> pc=0x24.
- Jump beats branch: pc=0x4000_0010, instr[25:0]=26'h0000100, jump=1, branch=1, alu_zero=1, commit -> pc=0x4000_0400.
- Stall and reset: stall=1 together with commit in EXEC -> pc and instr_valid unchanged for all stalled cycles. rst_n=0 mid-FETCH -> pc=RESET_PC, instr_valid=0, later imem_ready ignored.
- RETIRE_CNT_EN defined: 5 commits, with 1 commit issued during stall -> retire_cnt=4. Wraparound check with PC 0xFFFF_FFFC and no branch/jump -> next pc=0.
